// File: rtl/sym_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sym_timing_pkg
// Description : Shared types, defaults and half-period clamp for the
//               symbol timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sym_timing_pkg;

    typedef enum logic {MODE_1BPS, MODE_2BPS} sym_mode_t;

    localparam int DEFAULT_CNT_W = 7;
    localparam int DEFAULT_HALF  = 64;

    // Zero would stall the divider; anything above the counter range would
    // never reach its terminal count.
    function automatic int unsigned clamp_half(input int unsigned req,
                                               input int unsigned max_half);
        if (req == 32'd0)
            return 32'd1;
        else if (req > max_half)
            return max_half;
        else
            return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sym_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sym_div_ctrl
// Description : Pending/active register pair for the half-period and mode,
//               with busy flag; pending values commit on an apply pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sym_div_ctrl #(
    parameter int CNT_W        = sym_timing_pkg::DEFAULT_CNT_W,
    parameter int DEFAULT_HALF = sym_timing_pkg::DEFAULT_HALF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CNT_W:0]              i_div_half,
    input  logic                        i_div_load,
    input  logic                        i_mode,
    input  logic                        i_apply,
    output logic                        o_div_busy,
    output logic [CNT_W:0]              o_half,
    output sym_timing_pkg::sym_mode_t   o_mode
);
    import sym_timing_pkg::*;

    localparam int          HW         = CNT_W + 1;
    localparam int unsigned C_MAX_HALF = 32'd1 << CNT_W;

    logic [HW-1:0] w_clamped;
    logic [HW-1:0] r_pend_half;
    sym_mode_t     r_pend_mode;
    logic          r_busy;
    logic [HW-1:0] r_half;
    sym_mode_t     r_mode;

    assign w_clamped = HW'(clamp_half(32'(i_div_half), C_MAX_HALF));

    // A load coinciding with an apply still commits the older pending pair;
    // the new request stays pending for the following symbol boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_half <= HW'(DEFAULT_HALF);
            r_pend_mode <= MODE_1BPS;
            r_busy      <= 1'b0;
            r_half      <= HW'(DEFAULT_HALF);
            r_mode      <= MODE_1BPS;
        end else begin
            if (i_apply && r_busy) begin
                r_half <= r_pend_half;
                r_mode <= r_pend_mode;
            end
            if (i_div_load) begin
                r_pend_half <= w_clamped;
                r_pend_mode <= sym_mode_t'(i_mode);
                r_busy      <= 1'b1;
            end else if (i_apply) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_div_busy = r_busy;
    assign o_half     = r_half;
    assign o_mode     = r_mode;

endmodule
`default_nettype wire

// File: rtl/symbol_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : symbol_timing_gen
// Description : Run-time programmable 50%-duty symbol clock with symbol,
//               half and bit strobes plus an in-symbol phase index.
// Revision    : 1.0 - initial release
// ============================================================================
module symbol_timing_gen #(
    parameter int CNT_W        = sym_timing_pkg::DEFAULT_CNT_W,
    parameter int DEFAULT_HALF = sym_timing_pkg::DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W:0]   div_half,
    input  logic             div_load,
    input  logic             mode,
    output logic             div_busy,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W:0]   phase,
    output logic             sym_clk,
    output logic             sym_strobe,
    output logic             half_strobe,
    output logic             bit_strobe,
    output logic             bit_idx
);
    import sym_timing_pkg::*;

    localparam int HW = CNT_W + 1;

    logic [CNT_W-1:0] r_count;
    logic [HW-1:0]    r_phase;
    logic             r_sym_clk;
    logic             r_sym_strobe;
    logic             r_half_strobe;
    logic             r_bit_strobe;
    logic             r_bit_idx;

    logic [HW-1:0]    w_half;
    sym_mode_t        w_mode;
    logic [HW-1:0]    w_half_m1;
    logic             w_wrap;
    logic             w_rise;
    logic             w_fall_bit;

    sym_div_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_div_ctrl (
        .clk        (clk),
        .rst        (reset),
        .i_div_half (div_half),
        .i_div_load (div_load),
        .i_mode     (mode),
        .i_apply    (w_rise),
        .o_div_busy (div_busy),
        .o_half     (w_half),
        .o_mode     (w_mode)
    );

    assign w_half_m1  = w_half - HW'(1);
    assign w_wrap     = en && ({1'b0, r_count} == w_half_m1);
    assign w_rise     = w_wrap && !r_sym_clk;
    assign w_fall_bit = w_wrap && r_sym_clk && (w_mode == MODE_2BPS);

    // Strobes are registered alongside the toggle so they line up with the
    // first cycle of the new sym_clk level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= '0;
            r_phase       <= HW'(DEFAULT_HALF);
            r_sym_clk     <= 1'b0;
            r_sym_strobe  <= 1'b0;
            r_half_strobe <= 1'b0;
            r_bit_strobe  <= 1'b0;
            r_bit_idx     <= 1'b0;
        end else begin
            r_half_strobe <= w_wrap;
            r_sym_strobe  <= w_rise;
            r_bit_strobe  <= w_rise || w_fall_bit;
            if (en) begin
                if (w_wrap) begin
                    r_count   <= '0;
                    r_sym_clk <= ~r_sym_clk;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_rise) begin
                    r_phase   <= '0;
                    r_bit_idx <= 1'b0;
                end else begin
                    r_phase <= r_phase + HW'(1);
                end
                if (w_fall_bit)
                    r_bit_idx <= 1'b1;
            end
        end
    end

    assign count       = r_count;
    assign phase       = r_phase;
    assign sym_clk     = r_sym_clk;
    assign sym_strobe  = r_sym_strobe;
    assign half_strobe = r_half_strobe;
    assign bit_strobe  = r_bit_strobe;
    assign bit_idx     = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_symbol_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_symbol_timing_gen
// Description : Scoreboard bench for symbol_timing_gen against a
//               symbol-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_symbol_timing_gen;

    localparam int CNT_W    = 7;
    localparam int MAX_HALF = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] div_half = '0;
    logic       div_load = 1'b0;
    logic       mode = 1'b0;
    logic       div_busy;
    logic [6:0] count;
    logic [7:0] phase;
    logic       sym_clk, sym_strobe, half_strobe, bit_strobe, bit_idx;

    symbol_timing_gen #(.CNT_W(CNT_W), .DEFAULT_HALF(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .div_half    (div_half),
        .div_load    (div_load),
        .mode        (mode),
        .div_busy    (div_busy),
        .count       (count),
        .phase       (phase),
        .sym_clk     (sym_clk),
        .sym_strobe  (sym_strobe),
        .half_strobe (half_strobe),
        .bit_strobe  (bit_strobe),
        .bit_idx     (bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int ph;
        bit sclk;
        bit ss;
        bit hs;
        bit bs;
        bit bi;
        bit busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_no   = 0;

    // Reference model: the symbol is a position 0..2*half-1; the first half
    // of positions is sym_clk high. Reset parks the position at the low half.
    int m_half, m_mode, m_pend_half, m_pend_mode, m_busy, m_pos, m_bi;
    bit m_ss, m_hs, m_bs;

    function automatic int clamp_ref(int v);
        if (v < 1) return 1;
        if (v > MAX_HALF) return MAX_HALF;
        return v;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit ld, input int dh, input bit md);
        exp_t x;
        bit start;
        @(negedge clk);
        reset    = r;
        en       = e;
        div_load = ld;
        div_half = 8'(dh);
        mode     = md;
        start    = 1'b0;
        if (r) begin
            m_half = 64; m_mode = 0; m_busy = 0; m_pos = 64; m_bi = 0;
            m_ss = 0; m_hs = 0; m_bs = 0;
        end else begin
            m_ss = 0; m_hs = 0; m_bs = 0;
            if (e) begin
                if (m_pos + 1 == 2 * m_half) begin
                    start = 1'b1;
                    if (m_busy != 0) begin
                        m_half = m_pend_half;
                        m_mode = m_pend_mode;
                    end
                    m_pos = 0; m_ss = 1; m_hs = 1; m_bs = 1; m_bi = 0;
                end else begin
                    m_pos = m_pos + 1;
                    if (m_pos == m_half) begin
                        m_hs = 1;
                        if (m_mode != 0) begin
                            m_bs = 1; m_bi = 1;
                        end
                    end
                end
            end
            if (ld) begin
                m_pend_half = clamp_ref(dh);
                m_pend_mode = int'(md);
                m_busy      = 1;
            end else if (start) begin
                m_busy = 0;
            end
        end
        x.sclk = (m_pos < m_half);
        x.cnt  = x.sclk ? m_pos : m_pos - m_half;
        x.ph   = m_pos;
        x.ss   = m_ss;
        x.hs   = m_hs;
        x.bs   = m_bs;
        x.bi   = m_bi[0];
        x.busy = m_busy[0];
        exp_q.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    // Monitor: every clock the DUT presents a fresh output set.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_no++;
            n_checks++;
            if (int'(count) !== e.cnt || int'(phase) !== e.ph || sym_clk !== e.sclk ||
                sym_strobe !== e.ss || half_strobe !== e.hs || bit_strobe !== e.bs ||
                bit_idx !== e.bi || div_busy !== e.busy) begin
                n_errors++;
                $display("FAIL outputs cyc=%0d got cnt=%0d ph=%0d clk=%b ss=%b hs=%b bs=%b bi=%b busy=%b required cnt=%0d ph=%0d clk=%b ss=%b hs=%b bs=%b bi=%b busy=%b",
                         cyc_no, count, phase, sym_clk, sym_strobe, half_strobe, bit_strobe, bit_idx, div_busy,
                         e.cnt, e.ph, e.sclk, e.ss, e.hs, e.bs, e.bi, e.busy);
            end
        end
    end

    initial begin
        m_pend_half = 64; m_pend_mode = 0;
        // Defaults after reset
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(300);
        // Short divisor loaded mid-symbol
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(10);
        cyc(1'b0, 1'b1, 1'b1, 4, 1'b0);
        run(100);
        // QPSK framing
        cyc(1'b0, 1'b1, 1'b1, 8, 1'b1);
        run(100);
        // Enable gap in the high half
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(84);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, (i == 7), 3, 1'b1);
        run(150);
        // Clamp limits
        cyc(1'b0, 1'b1, 1'b1, 0, 1'b0);
        run(20);
        cyc(1'b0, 1'b1, 1'b1, 200, 1'b0);
        run(300);
        // Pending load discarded by reset right before the rising wrap
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(30);
        cyc(1'b0, 1'b1, 1'b1, 5, 1'b1);
        run(32);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0);
        run(140);
        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            int dh;
            dh = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 39) == 0), dh, 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
